// File: rtl/uart_fifo_periph_pkg.sv
// Shared definitions for the FIFO-buffered UART peripheral: register map, bit indices,
// FSM encodings and the CTRL reset value. The UART_LOOPBACK_EN macro enables CTRL bit5.
package uart_fifo_periph_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_CTRL   = 2'b10;
    localparam logic [1:0] ADDR_RXCNT  = 2'b11;

    localparam int ST_RX_OVR   = 0;
    localparam int ST_RX_BRK   = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_AVAIL = 3;
    localparam int ST_TX_IDLE  = 4;
    localparam int ST_RX_FULL  = 5;
    localparam int ST_TX_OVF   = 6;

    localparam int CTRL_IE_RX    = 0;
    localparam int CTRL_IE_TX    = 1;
    localparam int CTRL_IE_ERR   = 2;
    localparam int CTRL_TX_FLUSH = 3;
    localparam int CTRL_RX_FLUSH = 4;
    localparam int CTRL_LOOPBACK = 5;

    localparam logic [7:0] CTRL_RESET = 8'h05;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LOAD      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid pulse, break pulse on all-zero frame.
module uart_rx
    import uart_fifo_periph_pkg::*;
#(
    parameter int CLK_HZ   = 1_000_000,
    parameter int BIT_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_valid,
    output logic       rx_break,
    output logic [7:0] rx_data
);
    localparam int         CPB    = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam logic [15:0] FULL_M1 = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);

    rx_state_t   state;
    logic [1:0]  sync;
    logic [15:0] cnt;
    logic [2:0]  bits;

    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        rx_break <= 1'b0;
        if (reset) begin
            state   <= RX_IDLE;
            sync    <= 2'b11;
            cnt     <= '0;
            bits    <= '0;
            rx_data <= '0;
        end else begin
            sync <= {sync[0], rxd};
            case (state)
                RX_IDLE: begin
                    if (!sync[1]) begin
                        state <= RX_START;
                        cnt   <= HALF_M1;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        state <= sync[1] ? RX_IDLE : RX_DATA;
                        cnt   <= FULL_M1;
                        bits  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        rx_data <= {sync[1], rx_data[7:1]};
                        cnt     <= FULL_M1;
                        bits    <= bits + 1'b1;
                        if (bits == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        state <= RX_IDLE;
                        // Low stop bit with all-zero data is a break; other framing errors are dropped.
                        if (sync[1])               rx_valid <= 1'b1;
                        else if (rx_data == 8'h00) rx_break <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO with show-ahead read port; flush takes priority over push/pop.
module uart_sync_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    input  logic                  flush,
    output logic [7:0]            dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: latches tx_data on tx_en while idle, busy until the stop bit ends.
module uart_tx
    import uart_fifo_periph_pkg::*;
#(
    parameter int CLK_HZ   = 1_000_000,
    parameter int BIT_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy
);
    localparam int          CPB     = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam logic [15:0] FULL_M1 = 16'(CPB - 1);

    logic [9:0]  shift;
    logic [3:0]  nbits;
    logic [15:0] cnt;

    assign txd = shift[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            shift   <= '1;
            nbits   <= '0;
            cnt     <= '0;
            tx_busy <= 1'b0;
        end else if (!tx_busy) begin
            if (tx_en) begin
                shift   <= {1'b1, tx_data, 1'b0};
                nbits   <= 4'd10;
                cnt     <= FULL_M1;
                tx_busy <= 1'b1;
            end
        end else if (cnt == '0) begin
            shift <= {1'b1, shift[9:1]};
            nbits <= nbits - 1'b1;
            cnt   <= FULL_M1;
            if (nbits == 4'd1) tx_busy <= 1'b0;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_periph.sv
// CPU-bus UART peripheral with RX/TX FIFOs, interrupt enables, flush and sticky error flags.
// Define UART_LOOPBACK_EN to build the internal TX->RX loopback selected by CTRL bit5.
module uart_fifo_periph
    import uart_fifo_periph_pkg::*;
#(
    parameter int CLK_HZ        = 1_000_000,
    parameter int BIT_RATE      = 115200,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int TX_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ADDR,
    input  logic       CS,
    input  logic       WE,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       IRQ,
    input  logic       uart_rxd,
    output logic       uart_txd
);
    logic data_rd, data_wr, status_rd, ctrl_wr;
    logic rx_valid, rx_break, rx_pop, rx_flush, rx_full, rx_empty;
    logic tx_busy, tx_en, tx_pop, tx_flush, tx_full, tx_empty, tx_idle;
    logic [7:0] rx_data, rx_head, tx_head, status, ctrl_rd;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [8:0] rxcnt_ext;
    logic rx_line, tx_line;
    logic ie_rx, ie_tx, ie_err, loopback;
    logic rx_ovr, rx_brk, tx_ovf;
    tx_state_t tx_state;

    assign data_rd   = CS & ~WE & (ADDR == ADDR_DATA);
    assign status_rd = CS & ~WE & (ADDR == ADDR_STATUS);
    assign data_wr   = CS &  WE & (ADDR == ADDR_DATA);
    assign ctrl_wr   = CS &  WE & (ADDR == ADDR_CTRL);
    assign rx_pop    = data_rd & ~rx_empty;
    assign rx_flush  = ctrl_wr & DI[CTRL_RX_FLUSH];
    assign tx_flush  = ctrl_wr & DI[CTRL_TX_FLUSH];
    assign tx_idle   = (tx_count == '0) && (tx_state == TX_IDLE);

    uart_sync_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_valid), .din(rx_data), .pop(rx_pop),
        .flush(rx_flush), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart_sync_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(data_wr), .din(DI), .pop(tx_pop),
        .flush(tx_flush), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) u_rx (
        .clk(clk), .reset(reset), .rxd(rx_line), .rx_valid(rx_valid),
        .rx_break(rx_break), .rx_data(rx_data)
    );

    uart_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) u_tx (
        .clk(clk), .reset(reset), .tx_en(tx_en), .tx_data(tx_head),
        .txd(tx_line), .tx_busy(tx_busy)
    );

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk) begin
        if (reset)        loopback <= CTRL_RESET[CTRL_LOOPBACK];
        else if (ctrl_wr) loopback <= DI[CTRL_LOOPBACK];
    end
    assign rx_line  = loopback ? tx_line : uart_rxd;
    assign uart_txd = loopback ? 1'b1    : tx_line;
`else
    assign loopback = 1'b0;
    assign rx_line  = uart_rxd;
    assign uart_txd = tx_line;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_rx  <= CTRL_RESET[CTRL_IE_RX];
            ie_tx  <= CTRL_RESET[CTRL_IE_TX];
            ie_err <= CTRL_RESET[CTRL_IE_ERR];
        end else if (ctrl_wr) begin
            ie_rx  <= DI[CTRL_IE_RX];
            ie_tx  <= DI[CTRL_IE_TX];
            ie_err <= DI[CTRL_IE_ERR];
        end
    end

    // Sticky flags clear on a STATUS read; a set event in the same cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ovr <= 1'b0;
            rx_brk <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            rx_ovr <= (rx_ovr & ~status_rd) | (rx_valid & rx_full & ~rx_pop);
            rx_brk <= (rx_brk & ~status_rd) | rx_break;
            tx_ovf <= (tx_ovf & ~status_rd) | (data_wr & tx_full & ~tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_en    <= 1'b0;
            tx_pop   <= 1'b0;
        end else begin
            tx_en  <= 1'b0;
            tx_pop <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_empty && !tx_busy) begin
                        tx_state <= TX_LOAD;
                        tx_en    <= 1'b1;
                        tx_pop   <= 1'b1;
                    end
                end
                TX_LOAD:      tx_state <= TX_WAIT_BUSY;
                TX_WAIT_BUSY: if (tx_busy)  tx_state <= TX_WAIT_DONE;
                TX_WAIT_DONE: if (!tx_busy) tx_state <= TX_IDLE;
                default:      tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        status              = 8'h00;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_RX_BRK]   = rx_brk;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_AVAIL] = ~rx_empty;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_OVF]   = tx_ovf;
    end

    always_comb begin
        ctrl_rd                = 8'h00;
        ctrl_rd[CTRL_IE_RX]    = ie_rx;
        ctrl_rd[CTRL_IE_TX]    = ie_tx;
        ctrl_rd[CTRL_IE_ERR]   = ie_err;
        ctrl_rd[CTRL_LOOPBACK] = loopback;
    end

    assign rxcnt_ext = 9'(rx_count);

    always_comb begin
        DO = 8'h00;
        case (ADDR)
            ADDR_DATA:   DO = rx_empty ? 8'h00 : rx_head;
            ADDR_STATUS: DO = status;
            ADDR_CTRL:   DO = ctrl_rd;
            default:     DO = rxcnt_ext[8] ? 8'hFF : rxcnt_ext[7:0];
        endcase
    end

    assign IRQ = (ie_rx & ~rx_empty) | (ie_tx & tx_idle) | (ie_err & (rx_ovr | rx_brk | tx_ovf));

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph: bus accesses, serial stimulus and a serial decoder.
`timescale 1ns/1ps
module tb_uart_fifo_periph;
    localparam int CPB = 1_000_000 / 115200;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ADDR;
    logic       CS;
    logic       WE;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       IRQ;
    logic       uart_rxd;
    logic       uart_txd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_fifo_periph dut (
        .clk(clk), .reset(reset), .ADDR(ADDR), .CS(CS), .WE(WE), .DI(DI), .DO(DO),
        .IRQ(IRQ), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        CS = 1'b1; WE = 1'b1; ADDR = a; DI = d;
        @(negedge clk);
        CS = 1'b0; WE = 1'b0; ADDR = 2'b00;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        CS = 1'b1; WE = 1'b0; ADDR = a;
        #1 d = DO;
        @(negedge clk);
        CS = 1'b0; ADDR = 2'b00;
    endtask

    task automatic rx_send(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic tx_recv(output logic [7:0] b, output logic ok);
        int k;
        ok = 1'b0;
        b  = 8'h00;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) break;
        end
        if (k < 3000) begin
            repeat (CPB / 2) @(negedge clk);
            ok = (uart_txd === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            ok = ok & (uart_txd === 1'b1);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] b0, b1, b2;
        logic       ok0, ok1, ok2;
        logic       seen;
        logic       low_seen;
        int         k;

        reset = 1'b1; CS = 1'b0; WE = 1'b0; ADDR = 2'b00; DI = 8'h00; uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        check("reset_do_data", DO, 8'h00);
        check("reset_irq", {7'b0, IRQ}, 8'h00);
        check("reset_txd", {7'b0, uart_txd}, 8'h01);
        bus_read(2'b01, rd); check("reset_status", rd, 8'h10);
        bus_read(2'b10, rd); check("reset_ctrl", rd, 8'h05);
        bus_read(2'b11, rd); check("reset_rxcnt", rd, 8'h00);

        // Three bytes out on the serial line in order
        fork
            begin
                bus_write(2'b00, 8'h41);
                bus_write(2'b00, 8'h42);
                bus_write(2'b00, 8'h43);
            end
            begin
                tx_recv(b0, ok0);
                tx_recv(b1, ok1);
                tx_recv(b2, ok2);
            end
        join
        check("tx_byte0", b0, 8'h41);
        check("tx_byte1", b1, 8'h42);
        check("tx_byte2", b2, 8'h43);
        check("tx_frames_ok", {5'b0, ok0, ok1, ok2}, 8'h07);
        repeat (10) @(negedge clk);
        bus_read(2'b01, rd); check("tx_idle_after", rd, 8'h10);

        // Fill RX FIFO to depth, then one more byte overruns
        for (int i = 0; i < 16; i++) rx_send(8'(i));
        rx_send(8'hAA);
        repeat (4) @(negedge clk);
        bus_read(2'b11, rd); check("rxcnt_full", rd, 8'h10);
        check("irq_rx_full", {7'b0, IRQ}, 8'h01);
        bus_read(2'b01, rd); check("status_full_ovr", rd, 8'h39);

        // STATUS read coincident with an overrunning rx_valid: the flag survives
        seen = 1'b0;
        rd   = 8'h00;
        fork
            rx_send(8'hBB);
            begin
                for (k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (dut.rx_valid === 1'b1) break;
                end
                if (k < 400) begin
                    seen = 1'b1;
                    CS = 1'b1; WE = 1'b0; ADDR = 2'b01;
                    #1 rd = DO;
                    @(negedge clk);
                    CS = 1'b0; ADDR = 2'b00;
                end
            end
        join
        check("rx_valid_seen", {7'b0, seen}, 8'h01);
        check("status_same_cycle", rd, 8'h38);
        bus_read(2'b01, rd); check("status_ovr_kept", rd, 8'h39);
        bus_read(2'b01, rd); check("status_ovr_cleared", rd, 8'h38);

        // Drain in order, then empty read returns zero
        for (int i = 0; i < 16; i++) begin
            bus_read(2'b00, rd);
            check($sformatf("rx_data_%0d", i), rd, 8'(i));
        end
        bus_read(2'b00, rd); check("rx_data_empty", rd, 8'h00);
        bus_read(2'b11, rd); check("rxcnt_empty", rd, 8'h00);

        // TX overflow, then flush mid-stream; the in-flight character completes
        bus_write(2'b10, 8'h02);
        bus_read(2'b10, rd); check("ctrl_ie_tx", rd, 8'h02);
        check("irq_tx_idle", {7'b0, IRQ}, 8'h01);
        fork
            begin
                for (int i = 0; i < 20; i++) bus_write(2'b00, 8'h60 + 8'(i));
                check("irq_tx_busy", {7'b0, IRQ}, 8'h00);
                bus_read(2'b01, rd); check("status_tx_ovf", rd, 8'h44);
                bus_write(2'b10, 8'h0A);
                bus_read(2'b10, rd); check("ctrl_flush_reads0", rd, 8'h02);
                bus_read(2'b01, rd); check("status_after_flush", rd, 8'h00);
            end
            tx_recv(b0, ok0);
        join
        check("tx_inflight_byte", b0, 8'h60);
        check("tx_inflight_ok", {7'b0, ok0}, 8'h01);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (IRQ === 1'b1) break;
        end
        check("irq_after_flush", {7'b0, IRQ}, 8'h01);
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) low_seen = 1'b1;
        end
        check("txd_quiet_after_flush", {7'b0, low_seen}, 8'h00);
        bus_read(2'b01, rd); check("status_tx_flushed", rd, 8'h10);

`ifdef UART_LOOPBACK_EN
        bus_write(2'b10, 8'h21);
        bus_read(2'b10, rd); check("ctrl_loopback", rd, 8'h21);
        bus_write(2'b00, 8'h5A);
        low_seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) low_seen = 1'b1;
        end
        check("loop_txd_high", {7'b0, low_seen}, 8'h00);
        check("loop_irq", {7'b0, IRQ}, 8'h01);
        bus_read(2'b11, rd); check("loop_rxcnt", rd, 8'h01);
        bus_read(2'b00, rd); check("loop_rx_data", rd, 8'h5A);
        bus_write(2'b10, 8'h01);
`else
        bus_write(2'b10, 8'h21);
        bus_read(2'b10, rd); check("ctrl_no_loopback", rd, 8'h01);
`endif

        // Reset in the middle of a character returns the line high
        bus_write(2'b00, 8'h55);
        bus_write(2'b00, 8'h66);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) break;
        end
        check("midtx_started", {7'b0, uart_txd}, 8'h00);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midtx_reset_txd", {7'b0, uart_txd}, 8'h01);
        check("midtx_reset_irq", {7'b0, IRQ}, 8'h00);
        bus_read(2'b01, rd); check("midtx_reset_status", rd, 8'h10);
        bus_read(2'b10, rd); check("midtx_reset_ctrl", rd, 8'h05);
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) low_seen = 1'b1;
        end
        check("midtx_line_quiet", {7'b0, low_seen}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
